reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_if.sv | 48 ++++
 rtl/reg_file_sb.sv | 169 ++++++++++++++++
 tb/tb_reg_file_sb.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Bus bundle for the scoreboarded register file reg_file_sb.
//
// Signals (direction as seen by the slave, i.e. the register file):
//   clear_req     in   request a sequential clear of every entry
//   ready         out  high while the register file is in normal operation
//   reg_write_en  in   write strobe
//   write_reg     in   write address
//   write_data    in   write data
//   read_reg1/2   in   read addresses
//   read_data1/2  out  combinational read data
//   issue_en      in   mark issue_reg as pending (producer in flight)
//   issue_reg     in   register to mark pending
//   pend1/2       out  pending bit of read_reg1 / read_reg2
//
// Modports: master drives requests, slave is the register file.
// ---------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear_req;
    logic              ready;
    logic              reg_write_en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_reg;
    logic              pend1;
    logic              pend2;

    modport master (
        output clear_req, reg_write_en, write_reg, write_data,
               read_reg1, read_reg2, issue_en, issue_reg,
        input  ready, read_data1, read_data2, pend1, pend2
    );

    modport slave (
        input  clear_req, reg_write_en, write_reg, write_data,
               read_reg1, read_reg2, issue_en, issue_reg,
        output ready, read_data1, read_data2, pend1, pend2
    );
endinterface

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Two-read / one-write register file with a per-entry pending (scoreboard)
// bit and a sequential hardware clear that walks every entry, one per cycle.
//
// Ports:
//   clk    in   single clock, all state updates on the rising edge
//   reset  in   synchronous active-high reset; starts a full clear
//   bus    slave modport of reg_file_sb_if (requests, reads, pending bits)
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 is hard-wired zero and never pending
//
// Optional feature macro:
//   RF_BYPASS_EN  when defined, an IDLE write is forwarded to a read port
//                 addressing the same register in the same cycle, and that
//                 port's pending bit reflects the write (cleared unless the
//                 concurrent issue targets the same register).
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic clk,
    input  logic reset,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;

    logic              active;
    logic              write_ok;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              p1;
    logic              p2;

    // Reset is folded in so the outputs are already quiet while reset is held,
    // even before the first edge has moved the FSM into CLEAR.
    assign active   = (state == IDLE) && !reset;
    assign write_ok = active && bus.reg_write_en &&
                      !((ZERO_REG != 0) && (bus.write_reg == '0));

    // State register and clear counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a clear visits every entry once, leaving from LAST.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // Storage array. No reset here: contents are defined by the clear walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                regs[cnt] <= '0;
            end else if (write_ok) begin
                regs[bus.write_reg] <= bus.write_data;
            end
        end
    end

    // Pending bits: the write clears first, then the issue sets, so a
    // simultaneous issue and write to one register leaves it pending.
    always_comb begin
        pending_next = pending;
        if (write_ok) begin
            pending_next[bus.write_reg] = 1'b0;
        end
        if (active && bus.issue_en) begin
            pending_next[bus.issue_reg] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_next[0] = 1'b0;
        end
        if (state != IDLE) begin
            pending_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Read ports. Outputs are forced to zero whenever the file is not in
    // normal operation.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        p1  = 1'b0;
        p2  = 1'b0;
        if (active) begin
            rd1 = regs[bus.read_reg1];
            rd2 = regs[bus.read_reg2];
            p1  = pending[bus.read_reg1];
            p2  = pending[bus.read_reg2];
            if ((ZERO_REG != 0) && (bus.read_reg1 == '0)) begin
                rd1 = '0;
            end
            if ((ZERO_REG != 0) && (bus.read_reg2 == '0)) begin
                rd2 = '0;
            end
`ifdef RF_BYPASS_EN
            if (write_ok && (bus.read_reg1 == bus.write_reg)) begin
                rd1 = bus.write_data;
                p1  = bus.issue_en && (bus.issue_reg == bus.read_reg1);
            end
            if (write_ok && (bus.read_reg2 == bus.write_reg)) begin
                rd2 = bus.write_data;
                p2  = bus.issue_en && (bus.issue_reg == bus.read_reg2);
            end
`endif
        end
    end

    assign bus.ready      = active;
    assign bus.read_data1 = rd1;
    assign bus.read_data2 = rd2;
    assign bus.pend1      = p1;
    assign bus.pend2      = p2;
endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Directed, table-driven bench for reg_file_sb at default parameters.
// Expectations track RF_BYPASS_EN and ZERO_REG so the same table serves
// every build. Inputs change 1 time unit after the rising edge and outputs
// are sampled 1 unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 1;
    localparam int DEPTH    = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam bit ZR = (ZERO_REG != 0);

    logic clk;
    logic reset;

    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        bit          ie;
        logic [4:0]  ir;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        bit          e_p1;
        bit          e_p2;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear_req    = 1'b0;
        bus.reg_write_en = 1'b0;
        bus.write_reg    = '0;
        bus.write_data   = '0;
        bus.read_reg1    = '0;
        bus.read_reg2    = '0;
        bus.issue_en     = 1'b0;
        bus.issue_reg    = '0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.reg_write_en = v.we;
        bus.write_reg    = v.wr;
        bus.write_data   = v.wd;
        bus.read_reg1    = v.rr1;
        bus.read_reg2    = v.rr2;
        bus.issue_en     = v.ie;
        bus.issue_reg    = v.ir;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ready && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            bus.read_reg1 = 5'(i);
            bus.read_reg2 = 5'(DEPTH - 1 - i);
            #1;
            check_output($sformatf("%s.rd1[%0d]", tag, i), bus.read_data1, 32'h0);
            check_output($sformatf("%s.rd2[%0d]", tag, DEPTH - 1 - i), bus.read_data2, 32'h0);
            check_output($sformatf("%s.p1[%0d]", tag, i), {31'h0, bus.pend1}, 32'h0);
        end
    endtask

    initial begin
        int cycles;

        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;

        idle_inputs();
        reset = 1'b1;
        bus.read_reg1 = 5'd5;
        bus.read_reg2 = 5'd7;
        tick();

        // Outputs must be quiet while reset is held.
        check_output("reset.ready", {31'h0, bus.ready}, 32'h0);
        check_output("reset.rd1", bus.read_data1, 32'h0);
        check_output("reset.rd2", bus.read_data2, 32'h0);
        check_output("reset.pend", {30'h0, bus.pend1, bus.pend2}, 32'h0);

        reset = 1'b0;
        #1;
        check_output("init.ready_low", {31'h0, bus.ready}, 32'h0);
        wait_ready(cycles);
        check_output("init.clear_cycles", cycles, 32'd32);
        check_all_zero("init");

        // Table of single-cycle vectors; expectations are pre-edge values.
        vecs.push_back('{1, 5, 32'hDEADBEEF, 5, 0, 0, 0,
                         BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 0, 0});
        vecs.push_back('{1, 0, 32'h12345678, 5, 0, 0, 0,
                         32'hDEADBEEF, (BYP && !ZR) ? 32'h12345678 : 32'h0, 0, 0});
        vecs.push_back('{0, 0, 32'h0, 5, 0, 0, 0,
                         32'hDEADBEEF, ZR ? 32'h0 : 32'h12345678, 0, 0});
        vecs.push_back('{0, 0, 32'h0, 7, 5, 1, 7,
                         32'h0, 32'hDEADBEEF, 0, 0});
        vecs.push_back('{1, 7, 32'h11111111, 7, 5, 1, 7,
                         BYP ? 32'h11111111 : 32'h0, 32'hDEADBEEF, 1, 0});
        vecs.push_back('{0, 0, 32'h0, 7, 7, 0, 0,
                         32'h11111111, 32'h11111111, 1, 1});
        vecs.push_back('{1, 7, 32'h22222222, 7, 7, 0, 0,
                         BYP ? 32'h22222222 : 32'h11111111,
                         BYP ? 32'h22222222 : 32'h11111111, !BYP, !BYP});
        vecs.push_back('{0, 0, 32'h0, 7, 7, 0, 0,
                         32'h22222222, 32'h22222222, 0, 0});
        vecs.push_back('{1, 3, 32'hA5A5A5A5, 7, 3, 0, 0,
                         32'h22222222, BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0});
        vecs.push_back('{0, 0, 32'h0, 3, 3, 0, 0,
                         32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0});
        vecs.push_back('{0, 0, 32'h0, 0, 9, 1, 0,
                         ZR ? 32'h0 : 32'h12345678, 32'h0, 0, 0});
        vecs.push_back('{0, 0, 32'h0, 0, 9, 1, 9,
                         ZR ? 32'h0 : 32'h12345678, 32'h0, !ZR, 0});
        vecs.push_back('{0, 0, 32'h0, 0, 9, 0, 0,
                         ZR ? 32'h0 : 32'h12345678, 32'h0, !ZR, 1});
        vecs.push_back('{1, 9, 32'h00000099, 3, 9, 0, 0,
                         32'hA5A5A5A5, BYP ? 32'h00000099 : 32'h0, 0, !BYP});
        vecs.push_back('{0, 0, 32'h0, 3, 9, 0, 0,
                         32'hA5A5A5A5, 32'h00000099, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("v%0d.rd1", i), bus.read_data1, vecs[i].e_rd1);
            check_output($sformatf("v%0d.rd2", i), bus.read_data2, vecs[i].e_rd2);
            check_output($sformatf("v%0d.p1", i), {31'h0, bus.pend1}, {31'h0, vecs[i].e_p1});
            check_output($sformatf("v%0d.p2", i), {31'h0, bus.pend2}, {31'h0, vecs[i].e_p2});
            tick();
        end
        idle_inputs();

        // Fill r1..r31, then clear while hammering r9 with writes and issues.
        for (int i = 1; i < DEPTH; i++) begin
            bus.reg_write_en = 1'b1;
            bus.write_reg    = 5'(i);
            bus.write_data   = 32'h5A000000 | 32'(i);
            tick();
        end
        idle_inputs();
        bus.read_reg1 = 5'd9;
        bus.read_reg2 = 5'd31;
        #1;
        check_output("fill.r9", bus.read_data1, 32'h5A000009);
        check_output("fill.r31", bus.read_data2, 32'h5A00001F);

        // A write on the same edge as clear_req still lands, then is wiped.
        bus.clear_req    = 1'b1;
        bus.reg_write_en = 1'b1;
        bus.write_reg    = 5'd4;
        bus.write_data   = 32'hFFFFFFFF;
        tick();
        bus.clear_req    = 1'b0;
        bus.write_reg    = 5'd9;
        bus.write_data   = 32'hCAFEF00D;
        bus.issue_en     = 1'b1;
        bus.issue_reg    = 5'd9;
        bus.read_reg1    = 5'd9;
        bus.read_reg2    = 5'd4;
        #1;
        check_output("clr.ready", {31'h0, bus.ready}, 32'h0);
        check_output("clr.rd1", bus.read_data1, 32'h0);
        check_output("clr.rd2", bus.read_data2, 32'h0);
        check_output("clr.p1", {31'h0, bus.pend1}, 32'h0);
        wait_ready(cycles);
        idle_inputs();
        check_output("clr.cycles", cycles, 32'd32);
        check_all_zero("clr");

        // Reset in the middle of a clear restarts the walk from entry 0.
        bus.reg_write_en = 1'b1;
        bus.write_reg    = 5'd20;
        bus.write_data   = 32'h0BADF00D;
        bus.issue_en     = 1'b1;
        bus.issue_reg    = 5'd12;
        tick();
        idle_inputs();
        bus.read_reg1 = 5'd12;
        bus.read_reg2 = 5'd20;
        #1;
        check_output("pre.p1", {31'h0, bus.pend1}, 32'h1);
        check_output("pre.rd2", bus.read_data2, 32'h0BADF00D);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_output("rst_mid.ready", {31'h0, bus.ready}, 32'h0);
        wait_ready(cycles);
        check_output("rst_mid.cycles", cycles, 32'd32);
        check_all_zero("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
